// File: rtl/bls12_381_interrupt_unpack_if.sv
// Stream-in / element-out bundle for the BLS12-381 interrupt reply unpacker.
interface bls12_381_interrupt_unpack_if;
  logic [63:0]  dat;
  logic         val;
  logic         sop;
  logic         eop;
  logic         rdy;
  logic [380:0] elem;
  logic         elem_val;
  logic         elem_rdy;
  logic [2:0]   elem_num;
  logic         elem_last;
  logic [15:0]  index;
  logic [7:0]   dtype;
  logic         err_cmd;
  logic         err_len;
  logic [15:0]  pkt_cnt;

  modport master (
    output dat, val, sop, eop, elem_rdy,
    input  rdy, elem, elem_val, elem_num, elem_last, index, dtype, err_cmd, err_len, pkt_cnt
  );

  modport slave (
    input  dat, val, sop, eop, elem_rdy,
    output rdy, elem, elem_val, elem_num, elem_last, index, dtype, err_cmd, err_len, pkt_cnt
  );
endinterface

// File: rtl/bls12_381_interrupt_unpack.sv
// Unpacks SEND_INTERRUPT reply packets into 381-bit field elements.
// Optional slot pad-bit check: define BLS12_381_UNPACK_PAD_CHECK_EN.
//
// state   | meaning
// IDLE    | waiting for a beat with sop
// HDR     | collecting header beats, decode after the last one
// PAYLOAD | assembling 6-beat slots into elements
// DRAIN   | dropping beats of a rejected packet until eop
module bls12_381_interrupt_unpack #(
  parameter int          HDR_BEATS = 2,
  parameter int          CMD_LSB   = 0,
  parameter int          INDEX_LSB = 64,
  parameter int          DTYPE_LSB = 80,
  parameter logic [15:0] EXP_CMD   = 16'h0201  // BLS12_381_INTERRUPT_RPL
) (
  input logic clk,
  input logic rst_b,
  bls12_381_interrupt_unpack_if.slave bus
);
  localparam int HW = HDR_BEATS * 64;

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DRAIN} state_t;

  // point_type_t codes
  localparam logic [7:0] DT_SCALAR = 8'd0;
  localparam logic [7:0] DT_FP_AF  = 8'd3;
  localparam logic [7:0] DT_FP_JB  = 8'd4;
  localparam logic [7:0] DT_FP2_AF = 8'd5;
  localparam logic [7:0] DT_FP2_JB = 8'd6;

  function automatic logic [2:0] elem_count(input logic [7:0] t);
    case (t)
      DT_SCALAR: elem_count = 3'd1;
      DT_FP_AF:  elem_count = 3'd2;
      DT_FP_JB:  elem_count = 3'd3;
      DT_FP2_AF: elem_count = 3'd4;
      DT_FP2_JB: elem_count = 3'd6;
      default:   elem_count = 3'd0;
    endcase
  endfunction

  state_t         state, state_nxt;
  logic [3:0]     hdr_cnt, hdr_cnt_nxt;
  logic [2:0]     beat, beat_nxt, slot, slot_nxt, n_elem, n_elem_nxt, n_dec;
  logic [HW-65:0] hdr_q;
  logic [HW-1:0]  hdr_nxt;
  logic [319:0]   asm_q;
  logic [380:0]   elem_q;
  logic           elem_val_q, elem_last_q, elem_ok_q;
  logic [2:0]     elem_num_q;
  logic [15:0]    index_q, pkt_cnt_q;
  logic [7:0]     dtype_q;
  logic           err_cmd_q, err_len_q;
  logic           rdy_c, xfer, hdr_ld, hdr_dec, asm_we, ld_elem, ld_last, ld_ok;
  logic           err_cmd_c, err_len_c, pad_bad;
  logic           unused_hdr_bits;

  assign hdr_nxt         = {bus.dat, hdr_q};
  assign n_dec           = elem_count(hdr_nxt[DTYPE_LSB +: 8]);
  assign ld_last         = (slot == n_elem - 3'd1);
  assign unused_hdr_bits = ^hdr_nxt;

`ifdef BLS12_381_UNPACK_PAD_CHECK_EN
  assign pad_bad = |bus.dat[63:61];
`else
  assign pad_bad = 1'b0;
`endif

  // The 6th beat of a slot may only land once the output register is free or being taken.
  assign rdy_c = rst_b && !(state == PAYLOAD && beat == 3'd5 && elem_val_q && !bus.elem_rdy);
  assign xfer  = bus.val && rdy_c;

  always_comb begin
    state_nxt   = state;
    hdr_cnt_nxt = hdr_cnt;
    beat_nxt    = beat;
    slot_nxt    = slot;
    n_elem_nxt  = n_elem;
    hdr_ld      = 1'b0;
    hdr_dec     = 1'b0;
    asm_we      = 1'b0;
    ld_elem     = 1'b0;
    ld_ok       = 1'b0;
    err_cmd_c   = 1'b0;
    err_len_c   = 1'b0;
    if (xfer) begin
      if (bus.sop) begin
        // sop outside IDLE is a truncated packet; either way this beat starts a new header
        err_len_c = (state != IDLE) || bus.eop;
        hdr_ld    = 1'b1;
        if (bus.eop) begin
          state_nxt = IDLE;
        end else begin
          state_nxt   = HDR;
          hdr_cnt_nxt = 4'd1;
        end
      end else begin
        case (state)
          IDLE: err_len_c = 1'b1;
          HDR: begin
            hdr_ld      = 1'b1;
            hdr_cnt_nxt = hdr_cnt + 4'd1;
            if (bus.eop) begin
              err_len_c = 1'b1;
              state_nxt = IDLE;
            end else if (hdr_cnt + 4'd1 == 4'(HDR_BEATS)) begin
              hdr_dec = 1'b1;
              if (hdr_nxt[CMD_LSB +: 16] != EXP_CMD) begin
                err_cmd_c = 1'b1;
                state_nxt = DRAIN;
              end else if (n_dec == 3'd0) begin
                err_len_c = 1'b1;
                state_nxt = DRAIN;
              end else begin
                state_nxt  = PAYLOAD;
                beat_nxt   = 3'd0;
                slot_nxt   = 3'd0;
                n_elem_nxt = n_dec;
              end
            end
          end
          PAYLOAD: begin
            if (beat != 3'd5) begin
              asm_we   = 1'b1;
              beat_nxt = beat + 3'd1;
              if (bus.eop) begin
                err_len_c = 1'b1;
                state_nxt = IDLE;
              end
            end else if (pad_bad) begin
              err_len_c = 1'b1;
              state_nxt = bus.eop ? IDLE : DRAIN;
            end else begin
              ld_elem = 1'b1;
              ld_ok   = ld_last && bus.eop;
              if (ld_last) begin
                err_len_c = !bus.eop;
                state_nxt = bus.eop ? IDLE : DRAIN;
              end else if (bus.eop) begin
                err_len_c = 1'b1;
                state_nxt = IDLE;
              end else begin
                beat_nxt = 3'd0;
                slot_nxt = slot + 3'd1;
              end
            end
          end
          DRAIN: if (bus.eop) state_nxt = IDLE;
          default: state_nxt = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state       <= IDLE;
      hdr_cnt     <= '0;
      beat        <= '0;
      slot        <= '0;
      n_elem      <= '0;
      hdr_q       <= '0;
      asm_q       <= '0;
      elem_q      <= '0;
      elem_val_q  <= 1'b0;
      elem_num_q  <= '0;
      elem_last_q <= 1'b0;
      elem_ok_q   <= 1'b0;
      index_q     <= '0;
      dtype_q     <= '0;
      err_cmd_q   <= 1'b0;
      err_len_q   <= 1'b0;
      pkt_cnt_q   <= '0;
    end else begin
      state     <= state_nxt;
      hdr_cnt   <= hdr_cnt_nxt;
      beat      <= beat_nxt;
      slot      <= slot_nxt;
      n_elem    <= n_elem_nxt;
      err_cmd_q <= err_cmd_c;
      err_len_q <= err_len_c;
      if (hdr_ld) hdr_q <= hdr_nxt[HW-1:64];
      if (hdr_dec) begin
        index_q <= hdr_nxt[INDEX_LSB +: 16];
        dtype_q <= hdr_nxt[DTYPE_LSB +: 8];
      end
      if (asm_we) begin
        for (int k = 0; k < 5; k++) begin
          if (beat == 3'(k)) asm_q[k*64 +: 64] <= bus.dat;
        end
      end
      if (ld_elem) begin
        elem_q      <= {bus.dat[60:0], asm_q};
        elem_val_q  <= 1'b1;
        elem_num_q  <= slot;
        elem_last_q <= ld_last;
        elem_ok_q   <= ld_ok;
      end else if (bus.elem_rdy) begin
        elem_val_q <= 1'b0;
      end
      // only a last element from an error-free packet counts
      if (elem_val_q && bus.elem_rdy && elem_last_q && elem_ok_q) pkt_cnt_q <= pkt_cnt_q + 16'd1;
    end
  end

  assign bus.rdy       = rdy_c;
  assign bus.elem      = elem_q;
  assign bus.elem_val  = elem_val_q;
  assign bus.elem_num  = elem_num_q;
  assign bus.elem_last = elem_last_q;
  assign bus.index     = index_q;
  assign bus.dtype     = dtype_q;
  assign bus.err_cmd   = err_cmd_q;
  assign bus.err_len   = err_len_q;
  assign bus.pkt_cnt   = pkt_cnt_q;
endmodule

// File: tb/tb_bls12_381_interrupt_unpack.sv
// Directed bench for bls12_381_interrupt_unpack: packet parsing, errors, backpressure, reset.
module tb_bls12_381_interrupt_unpack;
  localparam logic [15:0] EXP_CMD = 16'h0201;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  bls12_381_interrupt_unpack_if bus();

  bls12_381_interrupt_unpack #(.EXP_CMD(EXP_CMD)) dut (
    .clk  (clk),
    .rst_b(rst_b),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;
  int exp_pkt = 0;
  int err_cmd_cnt = 0, err_len_cnt = 0, stab_err = 0;
  int rdy_mode = 0;
  logic [383:0] pay[6];
  logic [380:0] got_elem[$];
  logic [2:0]   got_num[$];
  logic         got_last[$];

  // consumer: drives elem_rdy, records accepted elements, error pulses and stall stability
  initial begin
    logic stalled;
    logic [380:0] held;
    logic [2:0] held_num;
    stalled = 1'b0;
    bus.elem_rdy = 1'b1;
    forever begin
      @(negedge clk);
      bus.elem_rdy = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 3);
      #1;
      if (stalled && bus.elem_val && (bus.elem !== held || bus.elem_num !== held_num)) stab_err++;
      stalled  = bus.elem_val && !bus.elem_rdy;
      held     = bus.elem;
      held_num = bus.elem_num;
      if (bus.elem_val && bus.elem_rdy) begin
        got_elem.push_back(bus.elem);
        got_num.push_back(bus.elem_num);
        got_last.push_back(bus.elem_last);
      end
      if (bus.err_cmd) err_cmd_cnt++;
      if (bus.err_len) err_len_cnt++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    got_elem.delete(); got_num.delete(); got_last.delete();
    err_cmd_cnt = 0; err_len_cnt = 0; stab_err = 0;
  endtask

  task automatic mk_pay(input logic [15:0] seed);
    for (int s = 0; s < 6; s++)
      for (int k = 0; k < 6; k++)
        pay[s][k*64 +: 64] = {4'h0, 4'(s), 8'(k), seed, 32'(s*6 + k + 1)};
  endtask

  task automatic send_beat(input logic [63:0] d, input logic s, input logic e);
    bit done;
    done = 1'b0;
    for (int g = 0; g < 500 && !done; g++) begin
      @(negedge clk);
      bus.dat = d; bus.sop = s; bus.eop = e; bus.val = 1'b1;
      #2;
      done = bus.rdy;
      @(posedge clk);
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL send_beat_timeout rdy=%0b required=1", bus.rdy);
    end
  endtask

  task automatic end_stream();
    @(negedge clk);
    bus.val = 1'b0; bus.sop = 1'b0; bus.eop = 1'b0;
  endtask

  // beats 0..last_beat; beat 0 carries sop, last_beat carries eop when use_eop
  task automatic send_pkt(input logic [15:0] cmd, input logic [15:0] idx, input logic [7:0] dt,
                          input int last_beat, input bit use_eop);
    for (int b = 0; b <= last_beat; b++) begin
      logic [63:0] d;
      int p;
      p = b - 2;
      if (b == 0) d = {48'h0, cmd};
      else if (b == 1) d = {40'h0, dt, idx};
      else if (p < 36) d = pay[p/6][(p%6)*64 +: 64];
      else d = 64'h0;
      send_beat(d, b == 0, use_eop && b == last_beat);
    end
    end_stream();
  endtask

  task automatic wait_drain();
    int g;
    repeat (3) @(negedge clk);
    g = 0;
    while (bus.elem_val && g < 400) begin
      @(negedge clk);
      g++;
    end
    checks++;
    if (bus.elem_val) begin
      failures++;
      $display("FAIL drain_timeout elem_val=%0b required=0", bus.elem_val);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_b = 1'b0; bus.val = 1'b0; bus.sop = 1'b0; bus.eop = 1'b0; bus.dat = '0;
    repeat (3) @(negedge clk);
    #3;
    checks++; if (bus.rdy !== 1'b0) begin failures++; $display("FAIL rst_rdy got=%0b exp=0", bus.rdy); end
    checks++; if (bus.elem_val !== 1'b0) begin failures++; $display("FAIL rst_elem_val got=%0b exp=0", bus.elem_val); end
    checks++; if (bus.pkt_cnt !== 16'h0) begin failures++; $display("FAIL rst_pkt_cnt got=%0h exp=0", bus.pkt_cnt); end
    checks++; if (bus.index !== 16'h0 || bus.dtype !== 8'h0) begin failures++; $display("FAIL rst_hdr got=%0h/%0h exp=0/0", bus.index, bus.dtype); end
    checks++; if (bus.elem !== 381'h0) begin failures++; $display("FAIL rst_elem got=%0h exp=0", bus.elem); end
    checks++; if (bus.err_cmd !== 1'b0 || bus.err_len !== 1'b0) begin failures++; $display("FAIL rst_err got=%0b%0b exp=00", bus.err_cmd, bus.err_len); end
    rst_b = 1'b1;
    #1;
    checks++; if (bus.rdy !== 1'b1) begin failures++; $display("FAIL rst_release_rdy got=%0b exp=1", bus.rdy); end
    repeat (2) @(negedge clk);
    clear_mon();
  endtask

  task automatic test_fp_jb();
    clear_mon();
    mk_pay(16'h1111);
    send_pkt(EXP_CMD, 16'hbeef, 8'd4, 19, 1'b1);
    wait_drain();
    exp_pkt++;
    checks++; if (got_elem.size() !== 3) begin failures++; $display("FAIL fpjb_count got=%0d exp=3", got_elem.size()); end
    for (int i = 0; i < 3 && i < got_elem.size(); i++) begin
      checks++;
      if (got_elem[i] !== pay[i][380:0] || got_num[i] !== 3'(i) || got_last[i] !== (i == 2)) begin
        failures++;
        $display("FAIL fpjb_elem%0d got=%0h num=%0d last=%0b exp=%0h num=%0d", i, got_elem[i], got_num[i], got_last[i], pay[i][380:0], i);
      end
    end
    checks++; if (bus.index !== 16'hbeef) begin failures++; $display("FAIL fpjb_index got=%0h exp=beef", bus.index); end
    checks++; if (bus.pkt_cnt !== 16'(exp_pkt)) begin failures++; $display("FAIL fpjb_pkt_cnt got=%0d exp=%0d", bus.pkt_cnt, exp_pkt); end
    checks++; if (err_len_cnt !== 0 || err_cmd_cnt !== 0) begin failures++; $display("FAIL fpjb_err got=%0d/%0d exp=0/0", err_cmd_cnt, err_len_cnt); end
  endtask

  task automatic test_fp2_jb_g2();
    clear_mon();
    pay[0] = 384'h024aa2b2f08f0a91260805272dc51051c6e47ad4fa403b02b4510b647ae3d1770bac0326a805bbefd48056c8c121bdb8;
    pay[1] = 384'h13e02b6052719f607dacd3a088274f65596bd0d09920b61ab5da61bbdc7f5049334cf11213945d57e5ac7d055d042b7e;
    pay[2] = 384'h0ce5d527727d6e118cc9cdc6da2e351aadfd9baa8cbdd3a76d429a695160d12c923ac9cc3baca289e193548608b82801;
    pay[3] = 384'h0606c4a02ea734cc32acd2b02bc28b99cb3e287e85a763af267492ab572e99ab3f370d275cec1da1aaa9075ff05f79be;
    pay[4] = 384'h1;
    pay[5] = 384'h0;
    send_pkt(EXP_CMD, 16'habcd, 8'd6, 37, 1'b1);
    wait_drain();
    exp_pkt++;
    checks++; if (got_elem.size() !== 6) begin failures++; $display("FAIL g2_count got=%0d exp=6", got_elem.size()); end
    for (int i = 0; i < 6 && i < got_elem.size(); i++) begin
      checks++;
      if (got_elem[i] !== pay[i][380:0] || got_num[i] !== 3'(i) || got_last[i] !== (i == 5)) begin
        failures++;
        $display("FAIL g2_elem%0d got=%0h num=%0d last=%0b exp=%0h num=%0d", i, got_elem[i], got_num[i], got_last[i], pay[i][380:0], i);
      end
    end
    checks++; if (bus.dtype !== 8'd6 || bus.index !== 16'habcd) begin failures++; $display("FAIL g2_hdr got=%0h/%0h exp=abcd/6", bus.index, bus.dtype); end
    checks++; if (bus.pkt_cnt !== 16'(exp_pkt)) begin failures++; $display("FAIL g2_pkt_cnt got=%0d exp=%0d", bus.pkt_cnt, exp_pkt); end
  endtask

  task automatic test_bad_cmd();
    clear_mon();
    mk_pay(16'h2222);
    send_pkt(16'h1234, 16'h0001, 8'd4, 19, 1'b1);
    wait_drain();
    checks++; if (err_cmd_cnt !== 1) begin failures++; $display("FAIL badcmd_err_cmd got=%0d exp=1", err_cmd_cnt); end
    checks++; if (err_len_cnt !== 0) begin failures++; $display("FAIL badcmd_err_len got=%0d exp=0", err_len_cnt); end
    checks++; if (got_elem.size() !== 0) begin failures++; $display("FAIL badcmd_count got=%0d exp=0", got_elem.size()); end
    checks++; if (bus.pkt_cnt !== 16'(exp_pkt)) begin failures++; $display("FAIL badcmd_pkt_cnt got=%0d exp=%0d", bus.pkt_cnt, exp_pkt); end
  endtask

  task automatic test_early_eop();
    clear_mon();
    mk_pay(16'h3333);
    send_pkt(EXP_CMD, 16'h0011, 8'd4, 10, 1'b1);
    wait_drain();
    checks++; if (err_len_cnt !== 1) begin failures++; $display("FAIL early_err_len got=%0d exp=1", err_len_cnt); end
    checks++; if (got_elem.size() !== 1) begin failures++; $display("FAIL early_count got=%0d exp=1", got_elem.size()); end
    checks++; if (bus.pkt_cnt !== 16'(exp_pkt)) begin failures++; $display("FAIL early_pkt_cnt got=%0d exp=%0d", bus.pkt_cnt, exp_pkt); end
    clear_mon();
    mk_pay(16'h4444);
    send_pkt(EXP_CMD, 16'h0022, 8'd0, 7, 1'b1);
    wait_drain();
    exp_pkt++;
    checks++;
    if (got_elem.size() !== 1 || err_len_cnt !== 0) begin
      failures++; $display("FAIL early_next_count got=%0d errs=%0d exp=1 errs=0", got_elem.size(), err_len_cnt);
    end else if (got_elem[0] !== pay[0][380:0] || got_last[0] !== 1'b1 || got_num[0] !== 3'd0) begin
      failures++; $display("FAIL early_next_elem got=%0h last=%0b exp=%0h last=1", got_elem[0], got_last[0], pay[0][380:0]);
    end
    checks++; if (bus.pkt_cnt !== 16'(exp_pkt)) begin failures++; $display("FAIL early_next_pkt_cnt got=%0d exp=%0d", bus.pkt_cnt, exp_pkt); end
  endtask

  task automatic test_backpressure();
    clear_mon();
    mk_pay(16'h7777);
    rdy_mode = 1;
    send_pkt(EXP_CMD, 16'h0777, 8'd6, 37, 1'b1);
    wait_drain();
    rdy_mode = 0;
    exp_pkt++;
    checks++; if (got_elem.size() !== 6) begin failures++; $display("FAIL bp_count got=%0d exp=6", got_elem.size()); end
    for (int i = 0; i < 6 && i < got_elem.size(); i++) begin
      checks++;
      if (got_elem[i] !== pay[i][380:0] || got_num[i] !== 3'(i) || got_last[i] !== (i == 5)) begin
        failures++;
        $display("FAIL bp_elem%0d got=%0h num=%0d exp=%0h num=%0d", i, got_elem[i], got_num[i], pay[i][380:0], i);
      end
    end
    checks++; if (stab_err !== 0) begin failures++; $display("FAIL bp_stable got=%0d exp=0", stab_err); end
    checks++; if (bus.pkt_cnt !== 16'(exp_pkt)) begin failures++; $display("FAIL bp_pkt_cnt got=%0d exp=%0d", bus.pkt_cnt, exp_pkt); end
  endtask

  task automatic test_too_long();
    clear_mon();
    mk_pay(16'h5555);
    send_pkt(EXP_CMD, 16'h0055, 8'd0, 8, 1'b1);
    wait_drain();
    checks++; if (err_len_cnt !== 1) begin failures++; $display("FAIL long_err_len got=%0d exp=1", err_len_cnt); end
    checks++; if (got_elem.size() !== 1) begin failures++; $display("FAIL long_count got=%0d exp=1", got_elem.size()); end
    checks++; if (bus.pkt_cnt !== 16'(exp_pkt)) begin failures++; $display("FAIL long_pkt_cnt got=%0d exp=%0d", bus.pkt_cnt, exp_pkt); end
  endtask

  task automatic test_sop_restart();
    clear_mon();
    mk_pay(16'h6666);
    send_pkt(EXP_CMD, 16'h0066, 8'd4, 4, 1'b0);
    send_pkt(EXP_CMD, 16'h0067, 8'd0, 7, 1'b1);
    wait_drain();
    exp_pkt++;
    checks++; if (err_len_cnt !== 1) begin failures++; $display("FAIL restart_err_len got=%0d exp=1", err_len_cnt); end
    checks++;
    if (got_elem.size() !== 1) begin
      failures++; $display("FAIL restart_count got=%0d exp=1", got_elem.size());
    end else if (got_elem[0] !== pay[0][380:0] || got_last[0] !== 1'b1) begin
      failures++; $display("FAIL restart_elem got=%0h exp=%0h", got_elem[0], pay[0][380:0]);
    end
    checks++; if (bus.index !== 16'h0067) begin failures++; $display("FAIL restart_index got=%0h exp=67", bus.index); end
    checks++; if (bus.pkt_cnt !== 16'(exp_pkt)) begin failures++; $display("FAIL restart_pkt_cnt got=%0d exp=%0d", bus.pkt_cnt, exp_pkt); end
  endtask

  task automatic test_bad_header();
    clear_mon();
    mk_pay(16'h8888);
    send_pkt(EXP_CMD, 16'h0088, 8'd7, 7, 1'b1);
    wait_drain();
    checks++; if (err_len_cnt !== 1 || got_elem.size() !== 0) begin failures++; $display("FAIL dtype_err got=%0d elems=%0d exp=1 elems=0", err_len_cnt, got_elem.size()); end
    clear_mon();
    send_beat(64'h0123, 1'b0, 1'b1);
    end_stream();
    wait_drain();
    checks++; if (err_len_cnt !== 1) begin failures++; $display("FAIL nosop_err_len got=%0d exp=1", err_len_cnt); end
    checks++; if (bus.pkt_cnt !== 16'(exp_pkt)) begin failures++; $display("FAIL badhdr_pkt_cnt got=%0d exp=%0d", bus.pkt_cnt, exp_pkt); end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    mk_pay(16'h9999);
    send_pkt(EXP_CMD, 16'h0099, 8'd4, 6, 1'b0);
    @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    exp_pkt = 0;
    mk_pay(16'haaaa);
    send_pkt(EXP_CMD, 16'h00aa, 8'd0, 7, 1'b1);
    wait_drain();
    exp_pkt++;
    checks++;
    if (got_elem.size() !== 1) begin
      failures++; $display("FAIL rstmid_count got=%0d exp=1", got_elem.size());
    end else if (got_elem[0] !== pay[0][380:0]) begin
      failures++; $display("FAIL rstmid_elem got=%0h exp=%0h", got_elem[0], pay[0][380:0]);
    end
    checks++; if (err_len_cnt !== 0) begin failures++; $display("FAIL rstmid_err_len got=%0d exp=0", err_len_cnt); end
    checks++; if (bus.pkt_cnt !== 16'(exp_pkt)) begin failures++; $display("FAIL rstmid_pkt_cnt got=%0d exp=%0d", bus.pkt_cnt, exp_pkt); end
  endtask

  initial begin
    bus.val = 1'b0; bus.sop = 1'b0; bus.eop = 1'b0; bus.dat = '0;
    test_reset();
    test_fp_jb();
    test_fp2_jb_g2();
    test_bad_cmd();
    test_early_eop();
    test_backpressure();
    test_too_long();
    test_sop_restart();
    test_bad_header();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bls12_381_interrupt_unpack.md
Name: bls12_381_interrupt_unpack

Overview:
- Sits directly downstream of bls12_381_top's tx stream, on the path that carries SEND_INTERRUPT reply packets toward the host-side consumer.
- Parses the 64-bit AXI-stream interrupt reply: header (cmd, index, data_type), then 48-byte payload slots.
- Validates packet header and length.
- Emits each 381-bit field element as one handshaked word, tagged with index, data type, element number and last flag.

Parameters:
- HDR_BEATS, 2, number of 64-bit header beats; header word hdr = {beat1, beat0}, beat0 in the LSBs.
- CMD_LSB, 0, bit offset of 16-bit cmd field in hdr.
- INDEX_LSB, 64, bit offset of 16-bit index field in hdr.
- DTYPE_LSB, 80, bit offset of 8-bit data_type field in hdr.
- EXP_CMD, BLS12_381_INTERRUPT_RPL, required cmd value.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset; synchronous, active-low
- i_dat  in  64  stream data, byte 0 in bits [7:0]
- i_val  in  1  stream valid
- i_sop  in  1  first beat of packet
- i_eop  in  1  last beat of packet
- o_rdy  out  1  stream ready
- o_elem  out  381  field element
- o_elem_val  out  1  element valid
- i_elem_rdy  in  1  element ready
- o_elem_num  out  3  element number within packet, 0..5
- o_elem_last  out  1  final element of packet
- o_index  out  16  header index, held for the whole packet
- o_dtype  out  8  header data_type, held for the whole packet
- o_err_cmd  out  1  one-cycle pulse: cmd mismatch
- o_err_len  out  1  one-cycle pulse: length mismatch or missing sop
- o_pkt_cnt  out  16  good packets fully emitted, wraps at 0xFFFF->0

Behaviour:
- Reset (i_rst==0 on an i_clk edge):
  - State goes to IDLE; all counters cleared.
  - o_elem_val=0, o_err_*=0, o_pkt_cnt=0, o_index=0, o_dtype=0, o_elem=0.
  - o_rdy=0 while in reset; o_rdy=1 on the first cycle after reset releases.
  - Reset mid-packet discards the partial packet and emits nothing further.
- A beat transfers when i_val&&o_rdy.
- Element count N by data_type (bls12_381_pkg point_type_t): SCALAR=1, FP_AF=2, FP_JB=3, FP2_AF=4, FP2_JB=6. Any other code is treated as a length error.
- Expected packet length = HDR_BEATS + 6*N beats.
- FSM:
  - IDLE:
    - Beat with i_sop -> HDR; beat counter=1.
    - Beat without i_sop -> pulse o_err_len, stay in IDLE (beat dropped).
  - HDR:
    - Accumulate beats. After beat HDR_BEATS, decode the fields and latch o_index/o_dtype.
    - cmd!=EXP_CMD -> pulse o_err_cmd, go to DRAIN.
    - Unknown dtype -> pulse o_err_len, go to DRAIN.
    - Otherwise -> PAYLOAD.
  - PAYLOAD:
    - Shift beats into a 384-bit assembly register (beat k of a slot fills bits [64k+:64]).
    - After the 6th beat, move bits [380:0] to the output register.
    - o_elem_val rises the cycle after the 6th beat (latency 1).
    - o_elem_num = slot count; o_elem_last = (slot==N-1).
  - DRAIN: accept and drop beats until a beat with i_eop transfers, then go to IDLE.
- Length checks in PAYLOAD:
  - i_eop on a beat other than the final expected beat -> pulse o_err_len; go to IDLE (i_eop seen) or DRAIN (packet too long).
  - Elements already emitted stay emitted; the consumer discards them on o_err_len.
  - i_sop seen outside IDLE -> pulse o_err_len; restart HDR from that beat.
- Backpressure:
  - The output register holds its value stable until i_elem_rdy.
  - o_rdy=0 only when the 6th beat of a slot is pending, o_elem_val=1 and i_elem_rdy=0 on that cycle.
  - Accept and refill in the same cycle is allowed, giving full throughput.
- o_pkt_cnt increments when the element with o_elem_last is accepted, provided no error occurred in that packet.
- Bits [383:381] of each slot are ignored unless the optional feature is enabled.

Optional Feature:
- Macro BLS12_381_UNPACK_PAD_CHECK_EN.
- Defined: a nonzero slot bit [383:381] -> pulse o_err_len, suppress that element, go to DRAIN (or IDLE if that beat carried i_eop).
- Undefined: pad bits are ignored, with no logic generated.

Test Plan:
- FP_JB packet, index 0xbeef, all elements valid, i_elem_rdy=1 -> 3 elements after 2+18 beats, o_elem_num 0,1,2; last on num 2; o_index=0xbeef; o_pkt_cnt=1.
- FP2_JB packet, index 0xabcd, elements = g2_point coordinates -> 6 elements matching g2_point in order; o_dtype=FP2_JB; o_pkt_cnt increments.
- cmd=0x1234 with valid length -> o_err_cmd pulses once; no elements; rest of packet drained; o_pkt_cnt unchanged.
- FP_JB packet with i_eop on beat 11 -> o_err_len pulses; FSM back in IDLE; the next good SCALAR packet emits 1 element.
- i_elem_rdy toggling at random 30% duty during an FP2_JB packet -> no lost or duplicated elements; o_elem stable while stalled.
- i_rst=0 for one cycle at beat 7 of an FP_JB packet, then a fresh SCALAR packet -> no stale elements; 1 element emitted; o_pkt_cnt=1.
